// File: rtl/pacman_sprite_renderer.sv
// Pac-Man sprite renderer: frame-latched hit test, sprite ROM addressing, 3-stage pixel pipeline and death animation.
// Optional macro PACMAN_DEBUG_BOX_EN adds a debug_box input that outlines the sprite box in palette index 4'hF.
module pacman_sprite_renderer #(
    parameter int unsigned SPR_SIZE     = 24,
    parameter int unsigned Y_OFFSET     = 6,
    parameter int unsigned WIN_XMIN     = 72,
    parameter int unsigned WIN_XMAX     = 408,
    parameter int unsigned NUM_MOVE_SPR = 9,
    parameter int unsigned DEATH_FRAMES = 11,
    parameter int unsigned DEATH_HOLD   = 4,
    parameter int unsigned ADDR_W       = 14
) (
    input  logic              Clk,
    input  logic              Reset,
`ifdef PACMAN_DEBUG_BOX_EN
    input  logic              debug_box,
`endif
    input  logic              frame_clk,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        pacmanPosX,
    input  logic [9:0]        pacmanPosY,
    input  logic [3:0]        pacman_sprite,
    input  logic              death,
    input  logic              restart,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              pixel_valid,
    output logic [3:0]        pixel_color,
    output logic              death_active,
    output logic              death_done
);

    localparam int unsigned SPR_AREA = SPR_SIZE * SPR_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DYING = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              frame_q;
    logic [9:0]        posx_q, posx_d;
    logic [9:0]        posy_q, posy_d;
    logic [3:0]        spr_q, spr_d;
    logic [7:0]        dframe_q, dframe_d;
    logic [7:0]        hold_q, hold_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit1_q, hit2_q;
    logic [3:0]        rdata_q;
    logic              valid_q, valid_d;
    logic [3:0]        color_q, color_d;

    logic              tick;
    logic [9:0]        row, col;
    logic              hit;
    logic [7:0]        idx;

`ifdef PACMAN_DEBUG_BOX_EN
    logic              dbg1_q, dbg2_q;
    logic              border;
`endif

    assign tick = frame_clk & ~frame_q;

    // Position and sprite latched once per frame so the box cannot tear mid-frame.
    always_comb begin
        posx_d = posx_q;
        posy_d = posy_q;
        spr_d  = spr_q;
        if (tick) begin
            posx_d = pacmanPosX;
            posy_d = pacmanPosY;
            spr_d  = pacman_sprite;
        end
    end

    always_comb begin
        state_d  = state_q;
        dframe_d = dframe_q;
        hold_d   = hold_q;
        unique case (state_q)
            IDLE: begin
                if (death && !restart) begin
                    state_d  = DYING;
                    dframe_d = '0;
                    hold_d   = '0;
                end
            end
            DYING: begin
                if (tick) begin
                    if (hold_q == 8'(DEATH_HOLD - 1)) begin
                        hold_d = '0;
                        if (dframe_q == 8'(DEATH_FRAMES - 1)) begin
                            state_d = DONE;
                        end else begin
                            dframe_d = dframe_q + 8'd1;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            DONE: begin
                if (restart) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 0: box test and ROM address in 10-bit wrap arithmetic.
    always_comb begin
        row = DrawY - posy_q - 10'(Y_OFFSET);
        col = DrawX - posx_q;
        hit = (row < 10'(SPR_SIZE)) && (col < 10'(SPR_SIZE)) &&
              (DrawX >= 10'(WIN_XMIN)) && (DrawX < 10'(WIN_XMAX));
        idx = (state_q == DYING) ? (8'(NUM_MOVE_SPR) + dframe_q) : {4'b0, spr_q};
        rom_addr_d = rom_addr_q;
        if (hit) begin
            rom_addr_d = ADDR_W'(32'(idx) * 32'(SPR_AREA) + 32'(row) * 32'(SPR_SIZE) + 32'(col));
        end
    end

`ifdef PACMAN_DEBUG_BOX_EN
    assign border = debug_box && hit &&
                    ((row == '0) || (row == 10'(SPR_SIZE - 1)) ||
                     (col == '0) || (col == 10'(SPR_SIZE - 1)));
`endif

    always_comb begin
        valid_d = hit2_q && (rdata_q != '0);
        color_d = valid_d ? rdata_q : '0;
`ifdef PACMAN_DEBUG_BOX_EN
        if (dbg2_q) begin
            valid_d = 1'b1;
            color_d = 4'hF;
        end
`endif
        if (state_q == DONE) begin
            valid_d = 1'b0;
            color_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            frame_q    <= 1'b0;
            posx_q     <= '0;
            posy_q     <= '0;
            spr_q      <= '0;
            dframe_q   <= '0;
            hold_q     <= '0;
            rom_addr_q <= '0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            color_q    <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_clk;
            posx_q     <= posx_d;
            posy_q     <= posy_d;
            spr_q      <= spr_d;
            dframe_q   <= dframe_d;
            hold_q     <= hold_d;
            rom_addr_q <= rom_addr_d;
            hit1_q     <= hit;
            hit2_q     <= hit1_q;
            rdata_q    <= rom_data;
            valid_q    <= valid_d;
            color_q    <= color_d;
        end
    end

`ifdef PACMAN_DEBUG_BOX_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dbg1_q <= 1'b0;
            dbg2_q <= 1'b0;
        end else begin
            dbg1_q <= border;
            dbg2_q <= dbg1_q;
        end
    end
`endif

    assign rom_addr     = rom_addr_q;
    assign pixel_valid  = valid_q;
    assign pixel_color  = color_q;
    assign death_active = (state_q == DYING);
    assign death_done   = (state_q == DONE);

endmodule

// File: tb/tb_pacman_sprite_renderer.sv
// Directed scoreboard bench for pacman_sprite_renderer: pixel expectations queued at drive time, popped at output time.
module tb_pacman_sprite_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  draw_x = '0, draw_y = '0;
    logic [9:0]  pos_x = '0, pos_y = '0;
    logic [3:0]  spr = '0;
    logic        death = 1'b0, restart = 1'b0;
    logic [13:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic        pixel_valid;
    logic [3:0]  pixel_color;
    logic        death_active, death_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       v;
        logic [3:0] c;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pacman_sprite_renderer dut (
        .Clk          (clk),
        .Reset        (rst),
`ifdef PACMAN_DEBUG_BOX_EN
        .debug_box    (1'b0),
`endif
        .frame_clk    (frame_clk),
        .DrawX        (draw_x),
        .DrawY        (draw_y),
        .pacmanPosX   (pos_x),
        .pacmanPosY   (pos_y),
        .pacman_sprite(spr),
        .death        (death),
        .restart      (restart),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .pixel_valid  (pixel_valid),
        .pixel_color  (pixel_color),
        .death_active (death_active),
        .death_done   (death_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame_tick(input logic [9:0] x, input logic [9:0] y, input logic [3:0] s);
        @(negedge clk);
        pos_x = x;
        pos_y = y;
        spr   = s;
        frame_clk = 1'b1;
        repeat (2) @(negedge clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One pixel presented for a single cycle; output must appear exactly 3 edges later.
    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [3:0] d,
                       input logic [13:0] exp_addr, input logic ev, input logic [3:0] ec);
        exp_t e;
        @(negedge clk);
        draw_x = x;
        draw_y = y;
        rom_data = d;
        sb.push_back('{v: ev, c: ec});
        @(posedge clk); #1;
        check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        check({tag, "_early1"}, 32'(pixel_valid), 32'd0);
        @(negedge clk);
        draw_x = '0;
        draw_y = '0;
        @(posedge clk); #1;
        check({tag, "_early2"}, 32'(pixel_valid), 32'd0);
        @(posedge clk); #1;
        n_vec++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(pixel_valid), 32'(e.v));
            check({tag, "_color"}, 32'(pixel_color), 32'(e.c));
        end
    endtask

    initial begin
        // Reset with random inputs
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            frame_clk = 1'($urandom);
            draw_x = 10'($urandom);
            draw_y = 10'($urandom);
            pos_x = 10'($urandom);
            pos_y = 10'($urandom);
            spr = 4'($urandom_range(0, 8));
            death = 1'($urandom);
            restart = 1'($urandom);
            rom_data = 4'($urandom);
            @(negedge clk);
        end
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_color", 32'(pixel_color), 32'd0);
        check("rst_active", 32'(death_active), 32'd0);
        check("rst_done", 32'(death_done), 32'd0);
        rst = 1'b0;
        frame_clk = 1'b0;
        death = 1'b0;
        restart = 1'b0;
        draw_x = '0;
        draw_y = '0;
        rom_data = '0;
        repeat (3) @(negedge clk);

        frame_tick(10'd228, 10'd336, 4'd8);
        pix("tl",    10'd228, 10'd342, 4'd5, 14'd4608, 1'b1, 4'd5);
        pix("br",    10'd251, 10'd365, 4'd7, 14'd5183, 1'b1, 4'd7);
        pix("right", 10'd252, 10'd365, 4'd7, 14'd5183, 1'b0, 4'd0);
        pix("transp",10'd240, 10'd350, 4'd0, 14'd4812, 1'b0, 4'd0);

        @(negedge clk);
        spr = 4'd2;
        pix("midfr", 10'd228, 10'd342, 4'd5, 14'd4608, 1'b1, 4'd5);
        frame_tick(10'd228, 10'd336, 4'd2);
        pix("newspr",10'd228, 10'd342, 4'd5, 14'd1152, 1'b1, 4'd5);

        frame_tick(10'd60, 10'd336, 4'd2);
        pix("clip",  10'd70, 10'd342, 4'd9, 14'd1152, 1'b0, 4'd0);
        pix("winmin",10'd72, 10'd342, 4'd9, 14'd1164, 1'b1, 4'd9);

        frame_tick(10'd228, 10'd336, 4'd2);
        @(negedge clk);
        death = 1'b1;
        @(negedge clk);
        death = 1'b0;
        check("dactive0", 32'(death_active), 32'd1);
        for (int i = 0; i < 44; i++) begin
            if (i % 4 == 0)
                pix("dframe", 10'd228, 10'd342, 4'd3, 14'((9 + i / 4) * 576), 1'b1, 4'd3);
            check("dying_active", 32'(death_active), 32'd1);
            check("dying_done", 32'(death_done), 32'd0);
            frame_tick(10'd228, 10'd336, 4'd2);
        end
        check("done_flag", 32'(death_done), 32'd1);
        check("done_active", 32'(death_active), 32'd0);
        pix("done_pix", 10'd228, 10'd342, 4'd5, 14'd1152, 1'b0, 4'd0);

        @(negedge clk);
        death = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        death = 1'b0;
        restart = 1'b0;
        check("rs_done", 32'(death_done), 32'd0);
        check("rs_active", 32'(death_active), 32'd0);
        pix("rs_pix", 10'd228, 10'd342, 4'd5, 14'd1152, 1'b1, 4'd5);

        // Reset while a valid pixel is in flight
        @(negedge clk);
        draw_x = 10'd228;
        draw_y = 10'd342;
        rom_data = 4'd5;
        @(negedge clk);
        rst = 1'b1;
        draw_x = '0;
        draw_y = '0;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_addr", 32'(rom_addr), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("mrst_valid", 32'(pixel_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pacman_sprite_renderer.md
Name: pacman_sprite_renderer

Overview:
Consumer side of the Pac-Man movement controller's render interface. It takes sprite index and position, and DrawX/DrawY from the VGA controller. It fetches palette indices from a synchronous sprite ROM and returns a pipelined, transparency-qualified pixel to the colour mapper. It owns the death-animation sequencing, during which the controller's sprite index is overridden.

Parameters:
SPR_SIZE, 24, sprite edge in screen pixels (square).
Y_OFFSET, 6, vertical offset added to pacmanPosY before the box test.
WIN_XMIN, 72, first visible maze column (inclusive).
WIN_XMAX, 408, end of visible maze columns (exclusive).
NUM_MOVE_SPR, 9, normal sprites in ROM, indices 0..8.
DEATH_FRAMES, 11, death sprites in ROM at indices NUM_MOVE_SPR..NUM_MOVE_SPR+DEATH_FRAMES-1.
DEATH_HOLD, 4, frame ticks each death sprite is shown.
ADDR_W, 14, ROM address width.

Ports:
Clk  in  1  50 MHz system clock.
Reset  in  1  synchronous, active-high reset.
frame_clk  in  1  frame strobe; rising edge detected in the Clk domain.
DrawX  in  10  current pixel column.
DrawY  in  10  current pixel row.
pacmanPosX  in  10  sprite box left edge from the movement controller.
pacmanPosY  in  10  sprite box top reference from the movement controller.
pacman_sprite  in  4  movement sprite index, 0..8.
death  in  1  one-Clk pulse; start the death animation.
restart  in  1  one-Clk pulse; leave DONE and return to IDLE.
rom_addr  out  ADDR_W  registered sprite ROM address.
rom_data  in  4  palette index; valid the cycle after rom_addr (ROM read latency 1).
pixel_valid  out  1  opaque Pac-Man pixel present.
pixel_color  out  4  palette index, qualified by pixel_valid.
death_active  out  1  high in DYING.
death_done  out  1  high in DONE.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, latched position/index = 0, death counters = 0, frame-edge history = 0.
- Frame tick: a 1-Clk pulse on each frame_clk 0->1 transition. Detection uses a 1-deep history register, so the tick occurs 1 Clk after the edge is sampled.
- On each tick, latch pacmanPosX, pacmanPosY and pacman_sprite. Rendering uses only latched values, so there is no mid-frame tearing.
- Hit test (stage 0, combinational; 10-bit unsigned wrap arithmetic):
  - row = DrawY - PosY_l - Y_OFFSET; col = DrawX - PosX_l.
  - hit = (row < SPR_SIZE) and (col < SPR_SIZE) and (WIN_XMIN <= DrawX < WIN_XMAX).
- Active index: idx = death-FSM index in DYING; otherwise the latched pacman_sprite.
- Address: idx*SPR_SIZE*SPR_SIZE + row*SPR_SIZE + col, truncated to ADDR_W.
- Pipeline timing:
  - Edge 1: rom_addr and hit1 registered.
  - Edge 2: rom_data and hit2 sampled.
  - Edge 3: pixel_color and pixel_valid registered.
  - Total latency is 3 Clk from DrawX/DrawY to pixel outputs.
- rom_addr holds its previous value when hit = 0.
- Transparency: pixel_valid = hit2 and (rom_data != 0). pixel_color = rom_data when valid, else 0.
- Death FSM:
  - IDLE: death -> DYING; dframe = 0, hold = 0.
  - DYING: on each tick, hold++.
    - When hold reaches DEATH_HOLD-1, hold = 0 and dframe++.
    - When dframe reaches DEATH_FRAMES-1 and its hold expires -> DONE.
    - Index = NUM_MOVE_SPR + dframe. death is ignored.
  - DONE: pixel_valid forced 0; death_done = 1; restart -> IDLE. death is ignored.
  - death and restart in the same cycle: restart wins (IDLE stays IDLE, DONE -> IDLE).
  - restart during DYING is ignored.
- A tick coinciding with the death pulse does not advance the hold counter.
- Reset mid-pipeline or mid-animation: everything returns to reset values on the next edge. No stale pixel is emitted after reset.

Optional Feature:
PACMAN_DEBUG_BOX_EN.
- Defined: adds an input debug_box (1). When debug_box = 1 and the pixel lies on the outer one-pixel border of the SPR_SIZE box (row or col equal to 0 or SPR_SIZE-1, and inside the window), then pixel_valid = 1 and pixel_color = 4'hF, overriding transparency. The override is pipelined with the same 3-Clk latency.
- Undefined: no port and no logic; behaviour is exactly as above.

Test Plan:
- Reset held 2 Clk with random inputs -> rom_addr = 0, pixel_valid = 0, pixel_color = 0, death_active = 0, death_done = 0.
- PosX = 228, PosY = 336, sprite = 8, one tick, then DrawX = 228, DrawY = 342 -> rom_addr = 4608 after 1 Clk; with rom_data = 5, pixel_color = 5 and pixel_valid = 1 exactly 3 Clk after the DrawX/DrawY sample.
- Same box, DrawX = 251, DrawY = 365 -> rom_addr = 5183; DrawX = 252 -> pixel_valid = 0. Also rom_data = 0 inside the box -> pixel_valid = 0.
- PosX = 60, DrawX = 70, DrawY in range -> pixel_valid = 0 (window clip); DrawX = 72 -> valid when rom_data != 0.
- Change pacman_sprite 8 -> 2 mid-frame without a tick -> address still uses 8; after the next tick, the base changes to 1152.
- death pulse with DEATH_HOLD = 4 -> index 9 for 4 ticks, then 10 and so on; death_done = 1 after 44 ticks. Then assert death and restart together -> IDLE, and the movement sprite is rendered again.
